// File: rtl/tdc_phase_encoder.sv
// Samples the TDC ring taps on FREF, encodes rise position and half-period run length, and block-averages run length.
// Latency: 3 cycles from sampling edge to valid/err; no backpressure, en low only inserts bubbles.
module tdc_phase_encoder #(
  parameter int N = 32,
  parameter int W = $clog2(N),
  parameter logic [N-1:0] POL_MASK = {(N/2){2'b10}},
  parameter int AVG_LOG2 = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] inv_out,
  output logic [W-1:0] phase,
  output logic [W-1:0] run_len,
  output logic         valid,
  output logic         err,
  output logic [W-1:0] avg_run,
  output logic         avg_valid
);

  localparam int AW = W + AVG_LOG2;
  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]        raw;
  logic                v1;
  logic [N-1:0]        rise_q;
  logic [N-1:0]        fall_q;
  logic                v2;

  logic [N-1:0]        pol_word;
  logic [N-1:0]        prev_tap;
  logic [N-1:0]        rise_d;
  logic [N-1:0]        fall_d;

  logic                rise_one;
  logic                fall_one;
  logic [W-1:0]        rise_idx;
  logic [W-1:0]        fall_idx;
  logic [W-1:0]        run_d;
  logic                accept;
  logic                reject;

  logic [AW-1:0]       acc;
  logic [AVG_LOG2-1:0] cnt;
  logic [AW-1:0]       acc_sum;
  logic                block_done;

  // prev_tap[i] holds tap (i-1) mod N, so tap 0 is compared against tap N-1.
  always_comb begin
    pol_word = raw ^ POL_MASK;
    prev_tap = {pol_word[N-2:0], pol_word[N-1]};
    rise_d   = pol_word & ~prev_tap;
    fall_d   = ~pol_word & prev_tap;
  end

  always_comb begin
    rise_one = (rise_q != '0) && ((rise_q & (rise_q - ONE_N)) == '0);
    fall_one = (fall_q != '0) && ((fall_q & (fall_q - ONE_N)) == '0);
    rise_idx = '0;
    fall_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (rise_q[i]) rise_idx = W'(i);
      if (fall_q[i]) fall_idx = W'(i);
    end
    run_d      = fall_idx - rise_idx;
    accept     = v2 & rise_one & fall_one;
    reject     = v2 & ~(rise_one & fall_one);
    acc_sum    = acc + AW'(run_d);
    block_done = accept && (cnt == '1);
  end

  // S1 is the only capture of the asynchronous taps; a metastable word fails the one-hot check in S3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw    <= '0;
      v1     <= 1'b0;
      rise_q <= '0;
      fall_q <= '0;
      v2     <= 1'b0;
    end else begin
      if (en) raw <= inv_out;
      v1     <= en;
      rise_q <= rise_d;
      fall_q <= fall_d;
      v2     <= v1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= '0;
      run_len   <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      avg_run   <= '0;
      avg_valid <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      valid     <= accept;
      err       <= reject;
      avg_valid <= block_done;
      if (accept) begin
        phase   <= rise_idx;
        run_len <= run_d;
        if (block_done) begin
          avg_run <= W'(acc_sum >> AVG_LOG2);
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + AVG_LOG2'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tdc_phase_encoder.sv
// Directed bench for tdc_phase_encoder with 4-sample averaging blocks.
module tb_tdc_phase_encoder;

  localparam int N = 32;
  localparam int W = 5;
  localparam int AVG_LOG2 = 2;
  localparam logic [31:0] MASK = 32'hAAAAAAAA;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] inv_out;
  logic [W-1:0] phase;
  logic [W-1:0] run_len;
  logic         valid;
  logic         err;
  logic [W-1:0] avg_run;
  logic         avg_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Field order: valid, err, avg_valid, phase, run_len, avg_run
  wire [17:0] obs = {valid, err, avg_valid, phase, run_len, avg_run};

  tdc_phase_encoder #(.N(N), .W(W), .AVG_LOG2(AVG_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .inv_out(inv_out),
    .phase(phase), .run_len(run_len), .valid(valid), .err(err),
    .avg_run(avg_run), .avg_valid(avg_valid)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic e, input logic [31:0] n_word);
    en      = e;
    inv_out = n_word ^ MASK;
  endtask

  function automatic logic [17:0] ov(input logic v, input logic e, input logic av,
                                     input int ph, input int rl, input int avg);
    return {v, e, av, W'(ph), W'(rl), W'(avg)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'h000000FF);
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", obs, 18'h0);
    end
    drive(1'b0, 32'h0);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic        se [6] = '{1, 1, 0, 0, 0, 0};
    logic [31:0] sn [6] = '{32'h000000FF, 32'hF000000F, 0, 0, 0, 0};
    logic [17:0] ex [6];
    ex = '{ov(0,0,0,0,0,0), ov(0,0,0,0,0,0), ov(0,0,0,0,0,0),
           ov(1,0,0,0,8,0), ov(1,0,0,28,8,0), ov(0,0,0,28,8,0)};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== ex[c]) begin
        n_fail++;
        $display("FAIL basic_wrap cyc %0d: got %h want %h", c, obs, ex[c]);
      end
      drive(se[c], sn[c]);
    end
  endtask

  task automatic test_reject();
    logic        se [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [31:0] sn [8] = '{32'h0, 32'h00FF00FF, 32'h0000000F, 32'h000000F0, 0, 0, 0, 0};
    logic [17:0] ex [8];
    ex = '{ov(0,0,0,28,8,0), ov(0,0,0,28,8,0), ov(0,0,0,28,8,0),
           ov(0,1,0,28,8,0), ov(0,1,0,28,8,0), ov(1,0,0,0,4,0),
           ov(1,0,1,4,4,6), ov(0,0,0,4,4,6)};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== ex[c]) begin
        n_fail++;
        $display("FAIL reject cyc %0d: got %h want %h", c, obs, ex[c]);
      end
      drive(se[c], sn[c]);
    end
  endtask

  task automatic test_average();
    logic        se [11] = '{1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0};
    logic [31:0] sn [11] = '{32'h000000FF, 0, 32'h0, 32'h0000FF00, 32'h000003FF, 0,
                             32'h0003FF00, 0, 0, 0, 0};
    logic [17:0] ex [11];
    ex = '{ov(0,0,0,4,4,6), ov(0,0,0,4,4,6), ov(0,0,0,4,4,6),
           ov(1,0,0,0,8,6), ov(0,0,0,0,8,6), ov(0,1,0,0,8,6),
           ov(1,0,0,8,8,6), ov(1,0,0,0,10,6), ov(0,0,0,0,10,6),
           ov(1,0,1,8,10,9), ov(0,0,0,8,10,9)};
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== ex[c]) begin
        n_fail++;
        $display("FAIL average cyc %0d: got %h want %h", c, obs, ex[c]);
      end
      drive(se[c], sn[c]);
    end
  endtask

  task automatic test_en_toggle();
    logic        se [7] = '{1, 0, 1, 0, 0, 0, 0};
    logic [31:0] sn [7] = '{32'h000000FF, 32'h000000FF, 32'h00000FF0, 0, 0, 0, 0};
    logic [17:0] ex [7];
    ex = '{ov(0,0,0,8,10,9), ov(0,0,0,8,10,9), ov(0,0,0,8,10,9),
           ov(1,0,0,0,8,9), ov(0,0,0,0,8,9), ov(1,0,0,4,8,9), ov(0,0,0,4,8,9)};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== ex[c]) begin
        n_fail++;
        $display("FAIL en_toggle cyc %0d: got %h want %h", c, obs, ex[c]);
      end
      drive(se[c], sn[c]);
    end
  endtask

  task automatic test_reset_midflight();
    logic        se [10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [31:0] sn [10] = '{0, 0, 32'h0000000F, 32'h0000000F, 32'h0000000F, 32'h000000FF,
                             0, 0, 0, 0};
    logic [17:0] ex [10];
    ex = '{ov(0,0,0,0,0,0), ov(0,0,0,0,0,0), ov(0,0,0,0,0,0), ov(0,0,0,0,0,0),
           ov(0,0,0,0,0,0), ov(1,0,0,0,4,0), ov(1,0,0,0,4,0), ov(1,0,0,0,4,0),
           ov(1,0,1,0,8,5), ov(0,0,0,0,8,5)};
    @(negedge clk) drive(1'b1, 32'h0000000F);
    @(negedge clk) drive(1'b1, 32'h0000FF00);
    @(negedge clk) drive(1'b1, 32'h000000FF);
    @(posedge clk);
    #2;
    drive(1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 18'h0) begin
      n_fail++;
      $display("FAIL midflight_async_clear: got %h want %h", obs, 18'h0);
    end
    @(negedge clk);
    n_checks++;
    if (obs !== 18'h0) begin
      n_fail++;
      $display("FAIL midflight_hold: got %h want %h", obs, 18'h0);
    end
    #2 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== ex[c]) begin
        n_fail++;
        $display("FAIL post_reset_block cyc %0d: got %h want %h", c, obs, ex[c]);
      end
      drive(se[c], sn[c]);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    inv_out = '0;
    test_reset();
    test_basic();
    test_reject();
    test_average();
    test_en_toggle();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
